instruction_fetch: RTL and testbench

Upstream fetch stage of the single-cycle RISC-V core. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. It presents the fetched instruction and its opcode field to the decode path (sign_extension, control), then holds them until the core retires the instruction. On retire, it advances the PC sequentially or to a redirect target, and traps misaligned targets.

---
 rtl/instruction_fetch_if.sv | 22 ++
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read channel between the fetch stage (master) and the
// instruction memory (slave): a single outstanding word read per req/ack.
interface instruction_fetch_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ack,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ack,
    output i_imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads one instruction word per retire over the
// imem channel, holds it for decode, and traps misaligned next-PC values.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  instruction_fetch_if.master        imem,
  output logic [31:0]                o_inst,
  output logic [6:0]                 o_opcode,
  output logic [31:0]                o_pc,
  output logic                       o_inst_valid,
  input  logic                       i_retire,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_target,
  output logic                       o_misaligned
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0]  OP_ALUI  = 7'b0010011;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    EXEC,
    FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [6:0]  opcode_q, opcode_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [31:0] next_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      inst_q   <= NOP_INST;
      opcode_q <= OP_ALUI;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      opcode_q <= opcode_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    opcode_d = opcode_q;
    req_d    = req_q;
    valid_d  = valid_q;
    mis_d    = mis_q;
    next_pc  = i_redirect ? i_redirect_target : (pc_q + 32'd4);

    unique case (state_q)
      BOOT: begin
        // Any ack seen here belongs to a request abandoned by reset.
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        req_d = 1'b1;
        if (imem.i_imem_ack) begin
          inst_d   = imem.i_imem_rdata;
          opcode_d = imem.i_imem_rdata[6:0];
          valid_d  = 1'b1;
          req_d    = 1'b0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (i_retire) begin
          valid_d = 1'b0;
          pc_d    = next_pc;
          if (next_pc[1:0] == 2'b00) begin
            req_d   = 1'b1;
            state_d = FETCH;
          end else begin
            mis_d   = 1'b1;
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        mis_d   = 1'b1;
      end
      default: begin
        state_d = BOOT;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem.o_imem_req  = req_q;
  assign imem.o_imem_addr = pc_q;
  assign o_inst           = inst_q;
  assign o_opcode         = opcode_q;
  assign o_pc             = pc_q;
  assign o_inst_valid     = valid_q;
  assign o_misaligned     = mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized instruction stream tracked by a transaction-level PC model.
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT 0: RESET_PC = 0
  logic        rst_n;
  logic        retire, redirect;
  logic [31:0] target;
  logic [31:0] inst, pc;
  logic [6:0]  opcode;
  logic        valid, mis;
  instruction_fetch_if imem0 ();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .imem              (imem0),
    .o_inst            (inst),
    .o_opcode          (opcode),
    .o_pc              (pc),
    .o_inst_valid      (valid),
    .i_retire          (retire),
    .i_redirect        (redirect),
    .i_redirect_target (target),
    .o_misaligned      (mis)
  );

  // DUT 1: RESET_PC at the top of the address space, for PC wrap
  logic        rst1_n;
  logic        retire1, redirect1;
  logic [31:0] target1;
  logic [31:0] inst1, pc1;
  logic [6:0]  opcode1;
  logic        valid1, mis1;
  instruction_fetch_if imem1 ();

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk             (clk),
    .i_rst_n           (rst1_n),
    .imem              (imem1),
    .o_inst            (inst1),
    .o_opcode          (opcode1),
    .o_pc              (pc1),
    .o_inst_valid      (valid1),
    .i_retire          (retire1),
    .i_redirect        (redirect1),
    .i_redirect_target (target1),
    .o_misaligned      (mis1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full visible state of DUT 0 against expected values
  task automatic chk_all(input string tag, input logic exp_req, input logic [31:0] exp_pc,
                         input logic [31:0] exp_inst, input logic exp_valid, input logic exp_mis);
    logic [31:0] w;
    w = exp_inst;
    chk({tag, ".req"},    {31'd0, imem0.o_imem_req}, {31'd0, exp_req});
    chk({tag, ".addr"},   imem0.o_imem_addr, exp_pc);
    chk({tag, ".pc"},     pc, exp_pc);
    chk({tag, ".inst"},   inst, exp_inst);
    chk({tag, ".opcode"}, {25'd0, opcode}, {25'd0, w[6:0]});
    chk({tag, ".valid"},  {31'd0, valid}, {31'd0, exp_valid});
    chk({tag, ".mis"},    {31'd0, mis}, {31'd0, exp_mis});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] exp_pc, word, last_inst;
  logic        do_redir;
  logic [31:0] tgt;

  initial begin
    rst_n = 1'b0; retire = 1'b0; redirect = 1'b0; target = '0;
    imem0.i_imem_ack = 1'b0; imem0.i_imem_rdata = '0;
    rst1_n = 1'b0; retire1 = 1'b0; redirect1 = 1'b0; target1 = '0;
    imem1.i_imem_ack = 1'b0; imem1.i_imem_rdata = '0;

    #12;
    chk_all("reset", 1'b0, 32'h0, NOP, 1'b0, 1'b0);

    // Boot and first fetch with three wait cycles
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("boot", 1'b1, 32'h0, NOP, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("wait", 1'b1, 32'h0, NOP, 1'b0, 1'b0);
    end
    imem0.i_imem_ack = 1'b1; imem0.i_imem_rdata = 32'h0001_70b7;
    tick();
    imem0.i_imem_ack = 1'b0;
    chk_all("fetch0", 1'b0, 32'h0, 32'h0001_70b7, 1'b1, 1'b0);
    chk("fetch0.lui", {25'd0, opcode}, {25'd0, 7'b0110111});

    // Sequential advance
    retire = 1'b1; redirect = 1'b0;
    tick();
    retire = 1'b0;
    chk_all("seq", 1'b1, 32'h4, 32'h0001_70b7, 1'b0, 1'b0);
    imem0.i_imem_ack = 1'b1; imem0.i_imem_rdata = 32'h00c0_0167;
    tick();
    chk_all("fetch1", 1'b0, 32'h4, 32'h00c0_0167, 1'b1, 1'b0);
    chk("fetch1.jalr", {25'd0, opcode}, {25'd0, 7'b1100111});
    imem0.i_imem_rdata = 32'hdead_beef;
    tick();
    imem0.i_imem_ack = 1'b0;
    chk_all("stray", 1'b0, 32'h4, 32'h00c0_0167, 1'b1, 1'b0);

    // Redirect without retire is ignored, then taken
    redirect = 1'b1; target = 32'h0000_0100;
    tick();
    chk_all("redir_noret", 1'b0, 32'h4, 32'h00c0_0167, 1'b1, 1'b0);
    retire = 1'b1;
    tick();
    retire = 1'b0; redirect = 1'b0;
    chk_all("redir", 1'b1, 32'h100, 32'h00c0_0167, 1'b0, 1'b0);

    // Randomized instruction stream against a PC-sequence model
    exp_pc = 32'h100;
    last_inst = 32'h00c0_0167;
    for (int n = 0; n < 40; n++) begin
      for (int w8 = 0; w8 < int'($urandom_range(0, 3)); w8++) begin
        retire = 1'($urandom); redirect = 1'($urandom); target = $urandom;
        tick();
        chk_all("r_wait", 1'b1, exp_pc, last_inst, 1'b0, 1'b0);
      end
      word = $urandom;
      retire = 1'($urandom); redirect = 1'($urandom);
      imem0.i_imem_ack = 1'b1; imem0.i_imem_rdata = word;
      tick();
      imem0.i_imem_ack = 1'b0; retire = 1'b0;
      last_inst = word;
      chk_all("r_fetch", 1'b0, exp_pc, word, 1'b1, 1'b0);
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
        imem0.i_imem_ack = 1'($urandom); imem0.i_imem_rdata = $urandom;
        redirect = 1'($urandom); target = $urandom;
        tick();
        chk_all("r_hold", 1'b0, exp_pc, word, 1'b1, 1'b0);
      end
      imem0.i_imem_ack = 1'($urandom); imem0.i_imem_rdata = $urandom;
      do_redir = 1'($urandom);
      tgt = $urandom & 32'hFFFF_FFFC;
      retire = 1'b1; redirect = do_redir; target = tgt;
      tick();
      retire = 1'b0; redirect = 1'b0; imem0.i_imem_ack = 1'b0;
      exp_pc = do_redir ? tgt : exp_pc + 32'd4;
      chk_all("r_retire", 1'b1, exp_pc, word, 1'b0, 1'b0);
    end

    // Misaligned redirect target traps and stays trapped
    imem0.i_imem_ack = 1'b1; imem0.i_imem_rdata = 32'h0000_0063;
    tick();
    imem0.i_imem_ack = 1'b0;
    chk_all("pre_mis", 1'b0, exp_pc, 32'h0000_0063, 1'b1, 1'b0);
    retire = 1'b1; redirect = 1'b1; target = 32'h0000_0102;
    tick();
    chk_all("mis", 1'b0, 32'h102, 32'h0000_0063, 1'b0, 1'b1);
    redirect = 1'b0; target = 32'h0000_0200;
    imem0.i_imem_ack = 1'b1; imem0.i_imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("mis_hold", 1'b0, 32'h102, 32'h0000_0063, 1'b0, 1'b1);
    end
    retire = 1'b0; imem0.i_imem_ack = 1'b0;

    // Reset leaves FAULT, then reset mid-fetch with an ack during reset
    rst_n = 1'b0;
    #1;
    chk_all("rst_fault", 1'b0, 32'h0, NOP, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("reboot", 1'b1, 32'h0, NOP, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid", 1'b0, 32'h0, NOP, 1'b0, 1'b0);
    imem0.i_imem_ack = 1'b1; imem0.i_imem_rdata = 32'h8000_0000;
    tick();
    chk_all("rst_ack", 1'b0, 32'h0, NOP, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_all("boot_ack", 1'b1, 32'h0, NOP, 1'b0, 1'b0);
    imem0.i_imem_rdata = 32'h0000_0297;
    tick();
    imem0.i_imem_ack = 1'b0;
    chk_all("post_rst_fetch", 1'b0, 32'h0, 32'h0000_0297, 1'b1, 1'b0);

    // PC wrap from 0xFFFFFFFC
    chk("wrap.reset_pc", pc1, 32'hFFFF_FFFC);
    rst1_n = 1'b1;
    tick();
    chk("wrap.req", {31'd0, imem1.o_imem_req}, 32'd1);
    chk("wrap.addr0", imem1.o_imem_addr, 32'hFFFF_FFFC);
    imem1.i_imem_ack = 1'b1; imem1.i_imem_rdata = NOP;
    tick();
    imem1.i_imem_ack = 1'b0;
    chk("wrap.valid", {31'd0, valid1}, 32'd1);
    retire1 = 1'b1;
    tick();
    retire1 = 1'b0;
    chk("wrap.addr", imem1.o_imem_addr, 32'h0000_0000);
    chk("wrap.mis", {31'd0, mis1}, 32'd0);
    chk("wrap.req2", {31'd0, imem1.o_imem_req}, 32'd1);
    chk("wrap.inst", inst1, NOP);
    chk("wrap.opcode", {25'd0, opcode1}, 32'h13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
